psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 30 +++
 rtl/psum_buffer.sv | 38 +++
 rtl/psum_accumulator.sv | 161 ++++++++++++++++
 tb/tb_psum_accumulator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// psum_accumulator_pkg
// Shared definitions for the partial-sum accumulator:
//   - state_t     : accumulator FSM states
//   - PSUM_BW, COL, DEPTH, KIJ_MAX : default parameter values
//   - clamp_kij() : maps an out-of-range tap count onto a single-tap pass
// -----------------------------------------------------------------------------
package psum_accumulator_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;
    localparam int KIJ_MAX = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // A tap count of zero or above the supported maximum degrades to one tap.
    function automatic logic [3:0] clamp_kij(input logic [3:0] n, input int kmax);
        if (n == 4'd0 || int'(n) > kmax) begin
            return 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/psum_buffer.sv
// -----------------------------------------------------------------------------
// psum_buffer
// depth x width register array holding one accumulated word per output
// position. One synchronous write port, one asynchronous read port, so an
// entry written on cycle N is visible on rdata from cycle N+1. No reset:
// the first tap of every pass overwrites each entry.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// -----------------------------------------------------------------------------
module psum_buffer #(
    parameter int width = 128,
    parameter int depth = 16,
    parameter int aw    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Accumulates partial sums popped from the output FIFO over num_kij kernel
// taps into a depth-entry buffer, then drains the buffer through a per-lane
// ReLU with a valid/ready handshake.
//
// Handshakes:
//   FIFO side  : ofifo_rd = ofifo_valid while in ACCUM; the head word psum_in
//                is consumed on every clock edge where ofifo_rd is 1.
//   Output side: a word transfers on every clock edge where out_valid and
//                out_ready are both 1; out_data holds while out_ready is 0.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : pass start pulse (only honoured in IDLE)
//   num_kij     : tap count, latched on accepted start
//   ofifo_valid : FIFO holds a word
//   psum_in     : FIFO head word, col lanes of psum_bw bits
//   ofifo_rd    : FIFO pop
//   out_data    : ReLU-applied accumulated word
//   out_valid   : out_data valid
//   out_ready   : downstream accepts out_data
//   busy        : not IDLE
//   done        : one-cycle pulse at pass completion
// -----------------------------------------------------------------------------
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH,
    parameter int kij_max = KIJ_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             num_kij,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] psum_in,
    output logic                   ofifo_rd,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = psum_bw * col;
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);

    state_t        state;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [3:0]    kij_cnt;
    logic [3:0]    kij_num;

    logic [W-1:0]  rd_word;
    logic [W-1:0]  wr_word;
    logic [W-1:0]  relu_word;
    logic [AW-1:0] buf_raddr;
    logic          last_word;

    assign ofifo_rd  = (state == ACCUM) && ofifo_valid;
    // The single read port serves the read-modify-write during ACCUM and
    // the output stream during DRAIN.
    assign buf_raddr = (state == DRAIN) ? rd_cnt : addr_cnt;
    assign last_word = (addr_cnt == LAST_ADDR) && (kij_cnt == kij_num - 4'd1);
    assign out_data  = out_valid ? relu_word : '0;

    psum_buffer #(
        .width (W),
        .depth (depth),
        .aw    (AW)
    ) u_buffer (
        .clk   (clk),
        .we    (ofifo_rd),
        .waddr (addr_cnt),
        .wdata (wr_word),
        .raddr (buf_raddr),
        .rdata (rd_word)
    );

    for (genvar g = 0; g < col; g++) begin : g_lane
        logic signed [psum_bw-1:0] old_v;
        logic signed [psum_bw-1:0] in_v;
        logic signed [psum_bw-1:0] sum_v;

        assign old_v = rd_word[g*psum_bw +: psum_bw];
        assign in_v  = psum_in[g*psum_bw +: psum_bw];
        // Wrapping two's-complement add; the first tap overwrites.
        assign sum_v = old_v + in_v;
        assign wr_word[g*psum_bw +: psum_bw]   = (kij_cnt == 4'd0) ? in_v : sum_v;
        assign relu_word[g*psum_bw +: psum_bw] = old_v[psum_bw-1] ? '0 : old_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            rd_cnt    <= '0;
            kij_cnt   <= '0;
            kij_num   <= 4'd1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        kij_num  <= clamp_kij(num_kij, kij_max);
                        addr_cnt <= '0;
                        kij_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (ofifo_valid) begin
                        if (last_word) begin
                            rd_cnt    <= '0;
                            out_valid <= 1'b1;
                            state     <= DRAIN;
                        end
                        if (addr_cnt == LAST_ADDR) begin
                            addr_cnt <= '0;
                            kij_cnt  <= kij_cnt + 4'd1;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt == LAST_ADDR) begin
                            rd_cnt    <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
// Directed passes through psum_accumulator: single tap with ReLU clipping,
// nine taps, signed wrap, randomised FIFO stalls with an output stall and a
// start pulse during DRAIN, reset mid-pass, and out-of-range tap counts.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;
    localparam int KIJ_MAX = 9;
    localparam int W       = PSUM_BW * COL;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   num_kij;
    logic         ofifo_valid;
    logic [W-1:0] psum_in;
    logic         ofifo_rd;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    psum_accumulator #(
        .psum_bw (PSUM_BW),
        .col     (COL),
        .depth   (DEPTH),
        .kij_max (KIJ_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_kij     (num_kij),
        .ofifo_valid (ofifo_valid),
        .psum_in     (psum_in),
        .ofifo_rd    (ofifo_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [W-1:0] feed_q[$];
    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [15:0] v);
        return {COL{v}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_pass(input logic [3:0] nk);
        @(negedge clk);
        start   = 1'b1;
        num_kij = nk;
        @(posedge clk);
        #1;
        start   = 1'b0;
        num_kij = 4'd5;   // must be ignored after the latch
        check("busy_after_start", W'(busy), W'(1));
    endtask

    // Presents feed_q words; pops one on each edge where ofifo_rd was seen.
    task automatic feed_all(input bit rand_valid);
        int  guard = 0;
        bit  rd_seen;
        while (feed_q.size() > 0 && guard < 3000) begin
            @(negedge clk);
            ofifo_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            psum_in     = ofifo_valid ? feed_q[0] : fill(16'hDEAD);
            #1;
            rd_seen = ofifo_rd;
            check("ofifo_rd", W'(ofifo_rd), W'(ofifo_valid));
            @(posedge clk);
            if (rd_seen) void'(feed_q.pop_front());
            guard++;
        end
        check("feed_left", W'(feed_q.size()), W'(0));
        feed_q.delete();
    endtask

    task automatic drain_all(input bit stall, input bit poke_start, input bit junk_valid);
        int hs = 0;
        int cyc = 0;
        int stall_left = 5;
        bit rdy;
        while (hs < DEPTH && cyc < 400) begin
            @(negedge clk);
            rdy = 1'b1;
            if (stall && hs == 6 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            out_ready   = rdy;
            start       = poke_start && (cyc == 2);
            num_kij     = 4'd1;
            ofifo_valid = junk_valid;
            psum_in     = fill(16'h1234);
            #1;
            check("out_valid", W'(out_valid), W'(1));
            if (junk_valid) check("ofifo_rd_drain", W'(ofifo_rd), W'(0));
            if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
            @(posedge clk);
            if (rdy && out_valid) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                hs++;
            end
            cyc++;
        end
        check("drain_count", W'(hs), W'(DEPTH));
        @(negedge clk);
        start       = 1'b0;
        out_ready   = 1'b0;
        ofifo_valid = 1'b0;
        #1;
        check("done_pulse", W'(done), W'(1));
        check("valid_after_drain", W'(out_valid), W'(0));
        check("busy_finish", W'(busy), W'(1));
        @(negedge clk);
        #1;
        check("done_low", W'(done), W'(0));
        check("busy_idle", W'(busy), W'(0));
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] words[$];
    logic [W-1:0] w;
    logic [W-1:0] e;
    logic [15:0]  s;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        num_kij     = 4'd0;
        ofifo_valid = 1'b1;
        psum_in     = fill(16'h5555);
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_done",      W'(done),      W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_ofifo_rd",  W'(ofifo_rd),  W'(0));
        check("rst_out_data",  out_data,      '0);
        @(negedge clk);
        reset       = 1'b0;
        ofifo_valid = 1'b0;

        // Single tap: lanes = addr-8, ReLU clips addr 0..8.
        start_pass(4'd1);
        for (int a = 0; a < DEPTH; a++) begin
            feed_q.push_back(fill(16'(a - 8)));
            exp_q.push_back(a <= 8 ? '0 : fill(16'(a - 8)));
        end
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b1);

        // Nine taps of +3 -> 27.
        start_pass(4'd9);
        for (int t = 0; t < 9; t++)
            for (int a = 0; a < DEPTH; a++) feed_q.push_back(fill(16'd3));
        for (int a = 0; a < DEPTH; a++) exp_q.push_back(fill(16'd27));
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b0);

        // Wrap: 0x7FFF + 1 = 0x8000 (negative) -> 0.
        start_pass(4'd2);
        for (int a = 0; a < DEPTH; a++) feed_q.push_back(fill(16'h7FFF));
        for (int a = 0; a < DEPTH; a++) feed_q.push_back(fill(16'h0001));
        for (int a = 0; a < DEPTH; a++) exp_q.push_back('0);
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b0);

        // Random data, random FIFO gaps, output stall, start poked in DRAIN.
        start_pass(4'd3);
        words.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = 16'($urandom_range(0, 65535));
            words.push_back(w);
            feed_q.push_back(w);
        end
        for (int a = 0; a < DEPTH; a++) begin
            for (int l = 0; l < COL; l++) begin
                s = '0;
                for (int t = 0; t < 3; t++) s = s + words[t*DEPTH + a][l*PSUM_BW +: PSUM_BW];
                e[l*PSUM_BW +: PSUM_BW] = s[15] ? 16'd0 : s;
            end
            exp_q.push_back(e);
        end
        feed_all(1'b1);
        drain_all(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("start_in_drain_ignored", W'(busy), W'(0));

        // Reset while tap 2 word 7 is presented, then a fresh single-tap pass.
        start_pass(4'd3);
        for (int i = 0; i < DEPTH + 7; i++) feed_q.push_back(fill(16'd50));
        feed_all(1'b0);
        @(negedge clk);
        reset       = 1'b1;
        ofifo_valid = 1'b1;
        psum_in     = fill(16'd50);
        @(posedge clk);
        #1;
        check("abort_busy",      W'(busy),      W'(0));
        check("abort_done",      W'(done),      W'(0));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_ofifo_rd",  W'(ofifo_rd),  W'(0));
        @(negedge clk);
        reset       = 1'b0;
        ofifo_valid = 1'b0;
        start_pass(4'd1);
        for (int a = 0; a < DEPTH; a++) begin
            for (int l = 0; l < COL; l++) begin
                w[l*PSUM_BW +: PSUM_BW] = ((a + l) % 4 == 0) ? 16'hFFFD : 16'(a * 8 + l);
                e[l*PSUM_BW +: PSUM_BW] = ((a + l) % 4 == 0) ? 16'd0    : 16'(a * 8 + l);
            end
            feed_q.push_back(w);
            exp_q.push_back(e);
        end
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b0);

        // num_kij = 0 and num_kij = 12 both act as one tap.
        start_pass(4'd0);
        for (int a = 0; a < DEPTH; a++) begin
            feed_q.push_back(fill(16'(a + 1)));
            exp_q.push_back(fill(16'(a + 1)));
        end
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b1);

        start_pass(4'd12);
        for (int a = 0; a < DEPTH; a++) begin
            feed_q.push_back(fill(16'(200 - a)));
            exp_q.push_back(fill(16'(200 - a)));
        end
        feed_all(1'b0);
        drain_all(1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        check("done_pulse_count", W'(done_cnt), W'(7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
